// File: rtl/spi_frame_tx.sv
// Serial frame transmitter for the LED driver channel-update link.
// One-deep holding register feeding a 17-bit MSB-first shifter with an idle gap after each frame.
module spi_frame_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [5:0]  wr_addr,
  input  logic [10:0] wr_value,
  output logic        wr_ready,
  output logic        s_clk,
  output logic        serial_out,
  output logic        busy,
  output logic        frame_done
);

  localparam int FRAME_BITS = 17;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    BIT_LAST  = 5'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [HW-1:0]           half_cnt_r, half_cnt_s;
  logic [GW-1:0]           gap_cnt_r, gap_cnt_s;
  logic [4:0]              bit_cnt_r, bit_cnt_s;
  // The frame MSB goes straight into serial_out on load, so the shifter keeps only the rest.
  logic [FRAME_BITS-2:0]   shift_r, shift_s;
  logic [FRAME_BITS-1:0]   hold_r, hold_s;
  logic                    ready_r, ready_s;
  logic                    sclk_r, sclk_s;
  logic                    sout_r, sout_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    half_end_s;

  assign wr_ready   = ready_r;
  assign s_clk      = sclk_r;
  assign serial_out = sout_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

  // Next-state and next-output computation for the holding register and the frame sequencer.
  always_comb begin
    state_s    = state_r;
    half_cnt_s = half_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    hold_s     = hold_r;
    ready_s    = ready_r;
    sclk_s     = sclk_r;
    sout_s     = sout_r;
    done_s     = 1'b0;
    half_end_s = (half_cnt_r == HALF_LAST);

    if (wr_valid && ready_r) begin
      hold_s  = {wr_addr, wr_value};
      ready_s = 1'b0;
    end else begin
      hold_s  = hold_r;
    end

    case (state_r)
      IDLE: begin
        if (!ready_r) begin
          shift_s    = hold_r[FRAME_BITS-2:0];
          sout_s     = hold_r[FRAME_BITS-1];
          bit_cnt_s  = 5'd0;
          half_cnt_s = '0;
          sclk_s     = 1'b0;
          ready_s    = 1'b1;
          state_s    = SETUP;
        end else begin
          state_s    = IDLE;
        end
      end
      SETUP, LOW: begin
        if (half_end_s) begin
          half_cnt_s = '0;
          sclk_s     = 1'b1;
          state_s    = HIGH;
        end else begin
          half_cnt_s = half_cnt_r + HW'(1);
        end
      end
      HIGH: begin
        if (half_end_s) begin
          half_cnt_s = '0;
          sclk_s     = 1'b0;
          if (bit_cnt_r == BIT_LAST) begin
            sout_s    = 1'b0;
            gap_cnt_s = '0;
            state_s   = GAP;
          end else begin
            sout_s    = shift_r[FRAME_BITS-2];
            shift_s   = {shift_r[FRAME_BITS-3:0], 1'b0};
            bit_cnt_s = bit_cnt_r + 5'd1;
            state_s   = LOW;
          end
        end else begin
          half_cnt_s = half_cnt_r + HW'(1);
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_s = '0;
          done_s    = 1'b1;
          state_s   = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
        end
      end
      default: begin
        sclk_s  = 1'b0;
        sout_s  = 1'b0;
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset drops the link to idle immediately and discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      half_cnt_r <= '0;
      gap_cnt_r  <= '0;
      bit_cnt_r  <= 5'd0;
      shift_r    <= '0;
      hold_r     <= '0;
      ready_r    <= 1'b1;
      sclk_r     <= 1'b0;
      sout_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      half_cnt_r <= half_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      hold_r     <= hold_s;
      ready_r    <= ready_s;
      sclk_r     <= sclk_s;
      sout_r     <= sout_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: two instances (CLK_DIV=4/GAP=16 and CLK_DIV=1/GAP=1) with a receiver-side monitor
// that rebuilds frames from s_clk rising edges and checks them against a queue of words written.
module tb_spi_frame_tx;

  localparam int CD0 = 4;
  localparam int GC0 = 16;
  localparam int CD1 = 1;
  localparam int GC1 = 1;

  logic clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  logic [1:0] wr_valid = 2'b00;
  logic [1:0][5:0]  wr_addr = '0;
  logic [1:0][10:0] wr_value = '0;
  logic [1:0] wr_ready, s_clk, serial_out, busy, frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: words the receiver should see, in order
  logic [16:0] exp_w [2][16];
  int exp_n [2] = '{0, 0};

  // receiver-side monitor state
  int cyc = 0;
  int nrise [2] = '{0, 0};
  int glitch [2] = '{0, 0};
  int t_busy [2] = '{0, 0};
  int t_done [2] = '{0, 0};
  int t_fall [2] = '{0, 0};
  int nfr [2] = '{0, 0};
  logic [16:0] bits [2] = '{17'd0, 17'd0};
  logic [1:0] p_sclk = 2'b00;
  logic [1:0] p_sout = 2'b00;
  logic [1:0] p_busy = 2'b00;
  logic [16:0] fr_bits [2][16];
  int fr_rises [2][16];
  int fr_len [2][16];
  int fr_tail [2][16];
  int fr_idle [2][16];

  always #5 clk = ~clk;

  spi_frame_tx #(.CLK_DIV(CD0), .GAP_CYCLES(GC0)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .wr_valid(wr_valid[0]), .wr_addr(wr_addr[0]),
    .wr_value(wr_value[0]), .wr_ready(wr_ready[0]), .s_clk(s_clk[0]),
    .serial_out(serial_out[0]), .busy(busy[0]), .frame_done(frame_done[0])
  );

  spi_frame_tx #(.CLK_DIV(CD1), .GAP_CYCLES(GC1)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .wr_valid(wr_valid[1]), .wr_addr(wr_addr[1]),
    .wr_value(wr_value[1]), .wr_ready(wr_ready[1]), .s_clk(s_clk[1]),
    .serial_out(serial_out[1]), .busy(busy[1]), .frame_done(frame_done[1])
  );

  // receiver model: sample on the falling clk edge, shift in data on each s_clk rise
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      p_sclk[d] <= s_clk[d];
      p_sout[d] <= serial_out[d];
      p_busy[d] <= busy[d];
      if (!rst_n[d]) begin
        nrise[d] <= 0;
      end else begin
        if (busy[d] && !p_busy[d]) begin
          t_busy[d] <= cyc;
          nrise[d]  <= 0;
          if (nfr[d] < 16) fr_idle[d][nfr[d]] <= cyc - t_done[d];
        end
        if (s_clk[d] && !p_sclk[d]) begin
          bits[d]  <= {bits[d][15:0], serial_out[d]};
          nrise[d] <= nrise[d] + 1;
        end
        if (!s_clk[d] && p_sclk[d]) t_fall[d] <= cyc;
        if (s_clk[d] && (serial_out[d] !== p_sout[d])) glitch[d] <= glitch[d] + 1;
        if (frame_done[d]) begin
          if (nfr[d] < 16) begin
            fr_bits[d][nfr[d]]  <= bits[d];
            fr_rises[d][nfr[d]] <= nrise[d];
            fr_len[d][nfr[d]]   <= cyc - t_busy[d];
            fr_tail[d][nfr[d]]  <= cyc - t_fall[d];
          end
          nfr[d]    <= nfr[d] + 1;
          t_done[d] <= cyc;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  function automatic int flen(input int d);
    return (d == 0) ? (2 * CD0 * 17 + GC0) : (2 * CD1 * 17 + GC1);
  endfunction

  // offer a word; while wr_ready is low keep wr_valid high with junk data on the bus
  task automatic send(input int d, input logic [5:0] a, input logic [10:0] v);
    int t = 0;
    wr_valid[d] = 1'b1;
    while (!wr_ready[d] && t < 1000) begin
      wr_addr[d]  = 6'($urandom);
      wr_value[d] = 11'($urandom);
      @(posedge clk); #1;
      t++;
    end
    wr_addr[d]  = a;
    wr_value[d] = v;
    @(posedge clk); #1;
    wr_valid[d] = 1'b0;
    wr_addr[d]  = 6'($urandom);
    wr_value[d] = 11'($urandom);
    chk("send_wait", 32'(t < 1000), 32'd1);
    chk("ready_drop", 32'(wr_ready[d]), 32'd0);
    if (exp_n[d] < 16) exp_w[d][exp_n[d]] = {a, v};
    exp_n[d]++;
  endtask

  task automatic wait_frames(input int d, input int n);
    int t = 0;
    while (nfr[d] < n && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("frame_count", 32'(nfr[d]), 32'(n));
  endtask

  task automatic chk_frame(input int d, input int i, input logic [16:0] want);
    chk("frame_bits", 32'(fr_bits[d][i]), 32'(want));
    chk("frame_rises", 32'(fr_rises[d][i]), 32'd17);
    chk("frame_len", 32'(fr_len[d][i]), 32'(flen(d)));
  endtask

  initial begin
    int t;
    int active;
    int base;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_sclk", 32'(s_clk[d]), 32'd0);
      chk("rst_sout", 32'(serial_out[d]), 32'd0);
      chk("rst_ready", 32'(wr_ready[d]), 32'd1);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_done", 32'(frame_done[d]), 32'd0);
    end
    rst_n = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(wr_ready[0]), 32'd1);
    chk("post_rst_busy", 32'(busy[0]), 32'd0);

    // single frame, MSB first
    send(0, 6'h05, 11'h4A3);
    wait_frames(0, 1);
    chk_frame(0, 0, 17'h02CA3);
    chk("single_gap", 32'(fr_tail[0][0]), 32'(GC0));

    // back-to-back extremes; second word waits in the holding register
    send(0, 6'd0, 11'd0);
    send(0, 6'd63, 11'd2047);
    t = 0;
    while (!frame_done[0] && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("b2b_ready_held", 32'(wr_ready[0]), 32'd0);
    wait_frames(0, 3);
    chk_frame(0, 1, 17'h00000);
    chk_frame(0, 2, 17'h1FFFF);
    chk("b2b_gap", 32'(fr_tail[0][1]), 32'(GC0));
    chk("b2b_idle", 32'(fr_idle[0][2]), 32'd1);

    // random words with junk on the bus while not ready
    for (int i = 0; i < 3; i++) send(0, 6'($urandom), 11'($urandom));
    wait_frames(0, 6);
    for (int i = 3; i < 6; i++) chk_frame(0, i, exp_w[0][i]);
    repeat (400) @(posedge clk);
    #1;
    chk("no_extra_frames", 32'(nfr[0]), 32'd6);

    // reset in the middle of a frame
    send(0, 6'($urandom), 11'($urandom));
    t = 0;
    while (nrise[0] < 9 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("reach_bit9", 32'(nrise[0] >= 9), 32'd1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("abort_sclk", 32'(s_clk[0]), 32'd0);
    chk("abort_sout", 32'(serial_out[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_ready", 32'(wr_ready[0]), 32'd1);
    exp_n[0]--;
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    send(0, 6'($urandom), 11'($urandom));
    wait_frames(0, 7);
    chk_frame(0, 6, exp_w[0][6]);

    // long idle: nothing must move
    base = nfr[0];
    active = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (s_clk[0] || busy[0] || frame_done[0]) active++;
    end
    chk("idle_activity", 32'(active), 32'd0);
    chk("idle_frames", 32'(nfr[0]), 32'(base));

    // fastest settings
    send(1, 6'h2A, 11'h555);
    send(1, 6'($urandom), 11'($urandom));
    wait_frames(1, 2);
    chk_frame(1, 0, 17'h15555);
    chk_frame(1, 1, exp_w[1][1]);
    chk("fast_idle", 32'(fr_idle[1][1]), 32'd1);
    chk("fast_gap", 32'(fr_tail[1][0]), 32'(GC1));

    repeat (20) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("sout_stable_high", 32'(glitch[d]), 32'd0);
      chk("total_frames", 32'(nfr[d]), 32'(exp_n[d]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- Serial transmitter that drives the channel-update link into the LED driver's SPI receiver. The receiver captures an 11-bit channel value and a 6-bit channel index.
- Accepts {addr, value} words from a local controller over a valid/ready handshake.
- Buffers one pending word, serializes each as a 17-bit frame (addr[5:0] then value[10:0], MSB first) on s_clk/serial_out, and inserts an idle gap between frames for receiver framing.

Parameters:
- CLK_DIV, 4, clk cycles per s_clk half-period (>=1).
- GAP_CYCLES, 16, clk cycles s_clk is held low after the last bit of a frame (>=1).
- FRAME_BITS, 17, bits per frame (fixed 6+11; not for override).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  word offered.
- wr_addr  in  6  channel index 0..63.
- wr_value  in  11  channel value 0..2047.
- wr_ready  out  1  holding register empty; transfer occurs when wr_valid & wr_ready.
- s_clk  out  1  serial clock to receiver; idles low.
- serial_out  out  1  serial data; changes only while s_clk low.
- busy  out  1  frame shifting or gap in progress.
- frame_done  out  1  one-cycle pulse at end of gap.

Behaviour:
- Reset (async assert, sync release): state IDLE, s_clk=0, serial_out=0, wr_ready=1, busy=0, frame_done=0, holding empty, counters 0.
- Holding register (1 deep):
  - Loads {wr_addr,wr_value} on handshake; wr_ready is registered and drops the next cycle.
  - Empties when the shifter loads from it.
  - A new word may be accepted while a frame is in flight, giving back-to-back frames.
- States:
  - IDLE: if holding full, load shifter (17 bits), drive serial_out=shifter[16], bit_cnt=0, enter SETUP. busy=1 from this cycle.
  - SETUP: s_clk=0 for CLK_DIV cycles, then enter HIGH.
  - HIGH: s_clk=1 for CLK_DIV cycles; receiver samples on the s_clk rising edge. At end, if bit_cnt==16, enter GAP with s_clk=0. Else shift left, serial_out=next bit, bit_cnt+1, enter LOW.
  - LOW: s_clk=0 for CLK_DIV cycles, then enter HIGH.
  - GAP: s_clk=0 and serial_out=0 for GAP_CYCLES cycles. On the last cycle pulse frame_done and return to IDLE; busy falls with the return to IDLE.
- Timing:
  - First s_clk rise comes CLK_DIV cycles after leaving IDLE.
  - Frame occupies 2*CLK_DIV*17 + GAP_CYCLES cycles, plus 1 IDLE cycle between back-to-back frames.
  - Exactly 17 rising edges per frame.
- Data is stable for >=CLK_DIV cycles before and after each rising edge. s_clk and serial_out are registered outputs (glitch-free).
- A word accepted during GAP is held until IDLE. It is never merged into the current frame.
- wr_addr/wr_value are ignored when wr_ready=0. The holding content is never overwritten.
- Reset mid-frame aborts immediately: s_clk=0 and the holding word is lost. The receiver resynchronizes because the link stays idle for at least the reset duration.
- Counters: half-period counter width clog2(CLK_DIV); gap counter width clog2(GAP_CYCLES+1); bit_cnt 5 bits; no wrap beyond terminal values.

Test Plan:
- Reset, then single write addr=6'h05 value=11'h4A3, CLK_DIV=4, GAP=16 -> 17 s_clk rises sampling 17'h02CA3 MSB first (0,0,0,1,0,1,1,0,0,1,0,1,0,0,0,1,1). frame_done fires 2*4*17+16=152 cycles after leaving IDLE.
- Two writes back-to-back (addr 0/val 0, then addr 63/val 2047) -> second accepted while first shifts; wr_ready=0 until the shifter loads word 2. Frames are 17'h00000 then 17'h1FFFF, separated by exactly 16 gap cycles plus 1 idle cycle.
- wr_valid held high with changing data while wr_ready=0 -> no extra frames, no corrupted bits, holding word unchanged.
- Assert rst_n low at bit 9 of a frame -> s_clk and serial_out go 0 asynchronously, busy=0, wr_ready=1. A following write transmits a complete 17-bit frame.
- CLK_DIV=1, GAP=1, value 11'h555 addr 6'h2A -> 17'h15555 sent, 35 cycles per frame. serial_out never changes while s_clk=1.
- Idle with wr_valid=0 for 1000 cycles -> s_clk=0, busy=0, no frame_done.
